// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: iterative 32-step shift-add multiplier and restoring divider.
// Optional MD_FAST_MUL_EN: single-cycle multiply in the accept cycle (IDLE -> DONE).
module hilo_md_ctrl #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        stall_o,
  output logic        busy_o,
  output logic        hi_we,
  output logic [31:0] hi_wdata,
  output logic        lo_we,
  output logic [31:0] lo_wdata
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*W-1:0]     acc;
  logic [W-1:0]       b_mag;
  logic [W-1:0]       rs_hold;
  logic               is_div;
  logic               neg_res;
  logic               rem_neg;
  logic               div_zero;

  // Operand decode for the accept cycle
  logic               is_md_op_c, signed_op_c, div_op_c, accept_c;
  logic               rs_neg_c, rt_neg_c;
  logic [W-1:0]       rs_mag_c, rt_mag_c;

  assign signed_op_c = (op == OP_MULT) || (op == OP_DIV);
  assign div_op_c    = (op == OP_DIV) || (op == OP_DIVU);
  assign is_md_op_c  = op_valid && ((op == OP_MULT) || (op == OP_MULTU) || div_op_c);
  assign accept_c    = (state == IDLE) && !flush && is_md_op_c;
  assign rs_neg_c    = signed_op_c && rs_val[W-1];
  assign rt_neg_c    = signed_op_c && rt_val[W-1];
  assign rs_mag_c    = rs_neg_c ? W'(-rs_val) : rs_val;
  assign rt_mag_c    = rt_neg_c ? W'(-rt_val) : rt_val;

  // One radix-2 step of each algorithm; acc holds {upper, lower} halves
  logic [W:0]         mul_sum_c;
  logic [2*W-1:0]     mul_step_c;
  logic               div_ge_c;
  logic [W-1:0]       div_rem_c;
  logic [2*W-1:0]     div_step_c;

  assign mul_sum_c  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? b_mag : {W{1'b0}})};
  assign mul_step_c = {mul_sum_c, acc[W-1:1]};
  assign div_ge_c   = acc[2*W-1:W-1] >= {1'b0, b_mag};
  assign div_rem_c  = W'(acc[2*W-1:W-1] - {1'b0, b_mag});
  assign div_step_c = div_ge_c ? {div_rem_c, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};

  // Final sign fix-up and divide-by-zero override
  logic [2*W-1:0]     prod_c;
  logic [W-1:0]       quot_c, rem_c, res_hi_c, res_lo_c;

  assign prod_c = neg_res ? (2*W)'(-acc) : acc;
  assign quot_c = neg_res ? W'(-acc[W-1:0]) : acc[W-1:0];
  assign rem_c  = rem_neg ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];

  always_comb begin
    res_hi_c = prod_c[2*W-1:W];
    res_lo_c = prod_c[W-1:0];
    if (is_div) begin
      res_hi_c = div_zero ? rs_hold : rem_c;
      res_lo_c = div_zero ? {W{1'b1}} : quot_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and combinational handshake/write outputs
  always_comb begin
    state_nxt = state;
    stall_o   = 1'b0;
    busy_o    = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_wdata  = '0;
    lo_wdata  = '0;
    if (rst) begin
      state_nxt = IDLE;
    end else begin
      busy_o = (state != IDLE);
      if (flush) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (op_valid) begin
              case (op)
                OP_MTHI: begin
                  hi_we    = 1'b1;
                  hi_wdata = rs_val;
                end
                OP_MTLO: begin
                  lo_we    = 1'b1;
                  lo_wdata = rs_val;
                end
                OP_MULT, OP_MULTU: begin
                  stall_o = 1'b1;
`ifdef MD_FAST_MUL_EN
                  state_nxt = DONE;
`else
                  state_nxt = BUSY;
`endif
                end
                OP_DIV, OP_DIVU: begin
                  stall_o   = 1'b1;
                  state_nxt = BUSY;
                end
                default: ;
              endcase
            end
          end
          BUSY: begin
            stall_o = 1'b1;
            if (cnt == CNT_W'(ITER - 1)) state_nxt = DONE;
          end
          DONE: begin
            hi_we     = 1'b1;
            lo_we     = 1'b1;
            hi_wdata  = res_hi_c;
            lo_wdata  = res_lo_c;
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      b_mag    <= '0;
      rs_hold  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            cnt      <= '0;
            is_div   <= div_op_c;
            neg_res  <= rs_neg_c ^ rt_neg_c;
            rem_neg  <= rs_neg_c;
            div_zero <= div_op_c && (rt_val == '0);
            rs_hold  <= rs_val;
            b_mag    <= rt_mag_c;
            acc      <= {{W{1'b0}}, rs_mag_c};
`ifdef MD_FAST_MUL_EN
            if (!div_op_c) acc <= (2*W)'(rs_mag_c) * (2*W)'(rt_mag_c);
`endif
          end
        end
        BUSY: begin
          cnt <= CNT_W'(cnt + 1'b1);
          acc <= is_div ? div_step_c : mul_step_c;
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
Multiply/divide sequencer that owns all writes into the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage and runs an iterative 32-step multiplier or divider. It stalls the pipeline while busy, then drives the hi/lo write-enable and data lines. It sits between EX-stage decode and the HI/LO register file.

Parameters:
ITER, 32, iterations per multiply/divide step sequence (operand width; fixed at 32 in this design)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
op_valid  input  1  EX stage presents an HI/LO-class op this cycle
op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored)
rs_val  input  32  operand A / dividend / MTHI-MTLO source
rt_val  input  32  operand B / divisor
flush  input  1  exception/flush from pipeline control
stall_o  output  1  hold EX and earlier stages
busy_o  output  1  state != IDLE
hi_we  output  1  HI write enable
hi_wdata  output  32  HI write data
lo_we  output  1  LO write enable
lo_wdata  output  32  LO write data

Behaviour:
- Reset (rst, synchronous, active-high; clock clk): state IDLE, counter 0, operand/accumulator registers 0. All outputs 0: stall_o, busy_o, hi_we, lo_we, hi_wdata, lo_wdata.
- States: IDLE, BUSY, DONE.
- IDLE, op_valid, op=MTHI: hi_we=1, hi_wdata=rs_val combinationally in same cycle; no stall; stay IDLE. MTLO is the same on lo_we/lo_wdata.
- IDLE, op_valid, op in {1..4}: stall_o=1 combinationally (accept cycle). Latch operand magnitudes, sign flags and op. Counter=0. Next state BUSY.
- BUSY: one radix-2 step per cycle; stall_o=1. After step ITER (counter==ITER-1), go to DONE.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
- DONE: hi_we=lo_we=1 with final results, stall_o=0, so the pipeline advances this cycle. op_valid is ignored in DONE because it is the same op still held. Next state IDLE.
- Latency: accept cycle + 32 BUSY cycles = 33 stall cycles. Write lands at the clock edge ending the DONE cycle.
- Results:
  - MULT(U): {hi,lo} = 64-bit product.
  - DIV(U): lo = quotient, hi = remainder.
- Signed handling: operate on magnitudes.
  - Product negated if operand signs differ.
  - Quotient negated if signs differ.
  - Remainder takes dividend sign.
- Divide by zero (DIV or DIVU): no trap, normal latency; lo=32'hFFFF_FFFF, hi=rs_val.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
- flush has priority in every state:
  - State -> IDLE, counter 0, hi_we=lo_we=0 that cycle (including DONE and MTHI/MTLO), stall_o=0.
  - No new op is accepted in the flush cycle.
- op=7 or NOP with op_valid: no action.
- Outputs hi_wdata/lo_wdata are 0 whenever their write enable is 0.

Optional Feature:
MD_FAST_MUL_EN
- Defined: MULT/MULTU compute the 64-bit product in the accept cycle with a single-cycle multiplier and go IDLE -> DONE. Stall is 1 cycle; write occurs in the following DONE cycle.
- Undefined: multiplies use the 32-cycle iterative path (33 stall cycles).
- Divide timing is unaffected in both cases.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall_o high 33 cycles, then one DONE cycle with hi_we=lo_we=1, hi=0xFFFFFFFE, lo=0x00000001. With MD_FAST_MUL_EN: stall 1 cycle, same values.
- MULT -2 x 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIVU 0x1234 / 0 -> after 33 stall cycles lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI rs=0xDEADBEEF, then MTLO rs=0x0BADF00D back-to-back -> hi_we then lo_we each high one cycle with those values; stall_o never asserted.
- DIV started, flush at BUSY cycle 10 -> state IDLE next cycle; no hi_we/lo_we pulse ever; stall_o low after flush. Next MULTU 3 x 5 completes with lo=15, hi=0.
- rst asserted mid-BUSY -> all outputs 0 next cycle, busy_o=0; no write occurs afterwards.
